video_timing_ctrl: RTL
======================

VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have parameter CW, default 16, which sets the width of every timing field and internal counter.
REQ-002 SHALL have ports i_CLK (input, 1, clock) and i_RST (input, 1, reset; asynchronous, active-low).
REQ-003 SHALL have ports i_start (input, 1, single-cycle start request) and i_stop (input, 1, single-cycle stop request).
REQ-004 SHALL have port i_cfg_update (input, 1, pulse that requests new config at the next frame boundary).
REQ-005 SHALL have timing inputs, each CW bits: i_hsw, i_hbp, i_hact, i_hfp (pixel clocks) and i_vsw, i_vbp, i_vact, i_vfp (lines).
REQ-006 SHALL have sync outputs o_VSYNC, o_HSYNC and o_DEN (output, 1 each, active-high, registered).
REQ-007 SHALL have o_DATA (output, 8, ramp pixel data, registered).
REQ-008 SHALL have status outputs o_busy (1, state != IDLE), o_frame_start (1, pulse) and o_cfg_err (1, pulse).

Function
REQ-009 SHALL implement the states IDLE, RUN and DRAIN.
- IDLE->RUN: i_start=1, i_stop=0, config valid.
- RUN->DRAIN: stop is pending.
- DRAIN->IDLE: after the last pixel of the current frame.
REQ-010 SHALL treat config as valid only if i_hsw, i_hact, i_vsw and i_vact are all nonzero and htotal = hsw+hbp+hact+hfp < 2^CW and vtotal = vsw+vbp+vact+vfp < 2^CW.
REQ-011 SHALL, on i_start in IDLE with invalid config, pulse o_cfg_err for 1 cycle and stay in IDLE.
REQ-012 SHALL copy all eight timing inputs into shadow registers on an accepted start; all counters and decoding use only the shadow values.
REQ-013 SHALL treat i_cfg_update in RUN as sticky-pending.
- Shadow reload: on the last pixel of a frame (hcnt=htotal-1, vcnt=vtotal-1).
- Invalid config at reload: o_cfg_err pulses, the old shadow is kept, and the pending flag clears.
REQ-014 SHALL run hcnt from 0 to htotal-1, then wrap to 0; vcnt increments on every hcnt wrap and wraps from vtotal-1 to 0.
REQ-015 SHALL drive, one cycle after the counter state they decode:
- o_HSYNC = (hcnt < hsw).
- o_VSYNC = (vcnt < vsw), which gives a VSYNC width of exactly htotal*vsw clocks.
- o_DEN = (hsw+hbp <= hcnt < hsw+hbp+hact) AND (vsw+vbp <= vcnt < vsw+vbp+vact).
REQ-016 SHALL drive o_DATA = (hcnt-hsw-hbp)[7:0] when the decoded DEN is 1, and 0 otherwise.
REQ-017 SHALL pulse o_frame_start for 1 cycle, aligned with the output cycle that shows position (0,0).
REQ-018 SHALL make the first output cycle after an accepted start correspond to position (0,0), which is 2 clocks after the i_start edge; the start-accept cycle itself drives all outputs 0.
REQ-019 SHALL latch i_stop in RUN as pending; the current frame always completes, so partial frames are never emitted.
REQ-020 SHALL, on the DRAIN->IDLE transition, drive o_VSYNC, o_HSYNC, o_DEN, o_DATA and o_busy to 0 on the next cycle and hold counters at 0.
REQ-021 SHALL ignore i_start outside IDLE.
REQ-022 SHALL ignore i_stop in IDLE.
REQ-023 SHALL, when i_start and i_stop are asserted together in IDLE, give stop priority so the state stays IDLE.
REQ-024 SHALL, when i_cfg_update and i_stop are both pending at a frame end, go to IDLE without reloading.
REQ-025 SHALL, when i_cfg_update arrives on the frame-end cycle, apply it in the same reload.

Reset
REQ-026 SHALL, while i_RST=0 (including mid-frame), asynchronously force state=IDLE, hcnt=vcnt=0, all shadow registers=0, all pending flags=0, and every output=0.
REQ-027 SHALL, after i_RST is released, stay in IDLE until an accepted i_start.

Verification
REQ-028 SHALL pass this basic frame check:
- Stimulus: hsw=2, hbp=3, hact=8, hfp=1, vsw=1, vbp=1, vact=4, vfp=1, then i_start.
- Response: htotal=14, frame period=98 clocks, HSYNC high 2 of every 14 clocks, VSYNC high 14 clocks, 32 DEN cycles per frame, o_DATA ramps 0..7 on each active line.
REQ-029 SHALL pass this stop check: i_stop at vcnt=2 in frame 1 -> frame 1 completes all 98 clocks, o_busy falls after it, and no further o_frame_start occurs.
REQ-030 SHALL pass this live-reload check: i_cfg_update with hact=10 mid-frame -> the next frame has htotal=16 and 40 DEN cycles, while the current frame is unchanged.
REQ-031 SHALL pass this invalid-config check:
- i_start with i_vact=0 -> o_cfg_err pulses and o_busy stays 0.
- i_cfg_update with i_hsw=0 in RUN -> o_cfg_err pulses and timing is unchanged.
REQ-032 SHALL pass this reset check: i_RST low at hcnt=5, vcnt=2 -> all outputs are 0 immediately; after release, outputs stay 0 until i_start.
REQ-033 SHALL pass this simultaneous-request check: i_start and i_stop in the same IDLE cycle -> state stays IDLE and o_busy=0.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Video timing generator: programmable H/V sync, data-enable and ramp pixel data.
// Latency: outputs show counter position one clock after it is held; first (0,0) two clocks after i_start.
// Backpressure: none; free-running once started, stop/config requests take effect at frame boundaries.
module video_timing_ctrl #(
  parameter int CW = 16  // must be >= 8 so the ramp can be taken from the low counter bits
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_cfg_update,
  input  logic [CW-1:0] i_hsw,
  input  logic [CW-1:0] i_hbp,
  input  logic [CW-1:0] i_hact,
  input  logic [CW-1:0] i_hfp,
  input  logic [CW-1:0] i_vsw,
  input  logic [CW-1:0] i_vbp,
  input  logic [CW-1:0] i_vact,
  input  logic [CW-1:0] i_vfp,
  output logic          o_VSYNC,
  output logic          o_HSYNC,
  output logic          o_DEN,
  output logic [7:0]    o_DATA,
  output logic          o_busy,
  output logic          o_frame_start,
  output logic          o_cfg_err
);

  localparam int EW = CW + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          stop_pend_q, stop_pend_d, upd_pend_q, upd_pend_d;
  logic          load_shadow, cfg_err_d;

  logic [CW-1:0] hsw_q, hbp_q, hact_q, hfp_q, vsw_q, vbp_q, vact_q, vfp_q;

  logic          vsync_q, hsync_q, den_q, busy_q, fs_q, err_q;
  logic [7:0]    data_q;

  // Live-input validation; totals are summed with two guard bits to catch overflow.
  logic [EW-1:0] in_htot, in_vtot;
  logic          in_ok;
  assign in_htot = EW'(i_hsw) + EW'(i_hbp) + EW'(i_hact) + EW'(i_hfp);
  assign in_vtot = EW'(i_vsw) + EW'(i_vbp) + EW'(i_vact) + EW'(i_vfp);
  assign in_ok   = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0) &&
                   (in_htot[EW-1:CW] == '0) && (in_vtot[EW-1:CW] == '0);

  // Region boundaries from the shadow copy; a validated shadow never overflows CW bits.
  logic [CW-1:0] h_act_lo, h_act_hi, h_tot, v_act_lo, v_act_hi, v_tot;
  assign h_act_lo = hsw_q + hbp_q;
  assign h_act_hi = h_act_lo + hact_q;
  assign h_tot    = h_act_hi + hfp_q;
  assign v_act_lo = vsw_q + vbp_q;
  assign v_act_hi = v_act_lo + vact_q;
  assign v_tot    = v_act_hi + vfp_q;

  logic h_last, v_last, frame_end, active, den_c;
  logic [7:0] pix_x;
  assign h_last    = (hcnt_q == h_tot - 1'b1);
  assign v_last    = (vcnt_q == v_tot - 1'b1);
  assign frame_end = h_last && v_last;
  assign active    = (state_q != IDLE);
  assign den_c     = active && (hcnt_q >= h_act_lo) && (hcnt_q < h_act_hi) &&
                     (vcnt_q >= v_act_lo) && (vcnt_q < v_act_hi);
  assign pix_x     = hcnt_q[7:0] - h_act_lo[7:0];

  // Next-state: start/stop handshake, raster counters, pending requests, reload decision.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    stop_pend_d = stop_pend_q;
    upd_pend_d  = upd_pend_q;
    load_shadow = 1'b0;
    cfg_err_d   = 1'b0;
    if (state_q != IDLE) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    case (state_q)
      IDLE: begin
        hcnt_d      = '0;
        vcnt_d      = '0;
        stop_pend_d = 1'b0;
        upd_pend_d  = 1'b0;
        // Stop wins over a simultaneous start.
        if (i_start && !i_stop) begin
          if (in_ok) begin
            state_d     = RUN;
            load_shadow = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_stop)       stop_pend_d = 1'b1;
        if (i_cfg_update) upd_pend_d  = 1'b1;
        if (frame_end) begin
          if (stop_pend_q || i_stop) begin
            // Stopping: drop any pending reload.
            state_d     = IDLE;
            stop_pend_d = 1'b0;
            upd_pend_d  = 1'b0;
          end else if (upd_pend_q || i_cfg_update) begin
            upd_pend_d = 1'b0;
            if (in_ok) load_shadow = 1'b1;
            else       cfg_err_d   = 1'b1;
          end
        end else if (stop_pend_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
          upd_pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and pending flags.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      upd_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      stop_pend_q <= stop_pend_d;
      upd_pend_q  <= upd_pend_d;
    end
  end

  // Shadow timing registers, loaded on accepted start or frame-boundary reload.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      hsw_q <= '0; hbp_q <= '0; hact_q <= '0; hfp_q <= '0;
      vsw_q <= '0; vbp_q <= '0; vact_q <= '0; vfp_q <= '0;
    end else if (load_shadow) begin
      hsw_q <= i_hsw; hbp_q <= i_hbp; hact_q <= i_hact; hfp_q <= i_hfp;
      vsw_q <= i_vsw; vbp_q <= i_vbp; vact_q <= i_vact; vfp_q <= i_vfp;
    end
  end

  // Registered decode of the current raster position; busy is delayed to line up with it.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      den_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vsync_q <= active && (vcnt_q < vsw_q);
      hsync_q <= active && (hcnt_q < hsw_q);
      den_q   <= den_c;
      data_q  <= den_c ? pix_x : 8'd0;
      busy_q  <= active;
      fs_q    <= active && (hcnt_q == '0) && (vcnt_q == '0);
      err_q   <= cfg_err_d;
    end
  end

  assign o_VSYNC       = vsync_q;
  assign o_HSYNC       = hsync_q;
  assign o_DEN         = den_q;
  assign o_DATA        = data_q;
  assign o_busy        = busy_q;
  assign o_frame_start = fs_q;
  assign o_cfg_err     = err_q;

endmodule
